instr_fetch_ctrl: RTL and testbench



---
 rtl/instr_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/dispatch controller: owns PC and IR, fetches one word, hands it to the execute FSMs until they report done.
// Latency: FETCH, LATCH and DECODE precede EXEC; RETIRE follows it, so overhead is 4 cycles plus the execute length.
// Backpressure: FETCH holds mem_rd until mem_ready; EXEC holds until exec_done or the timeout, which faults and halts.
module instr_fetch_ctrl #(
    parameter int                 ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter logic [15:0]        OP_VALID     = 16'h0006,
    parameter logic [3:0]         OP_HALT      = 4'b1111,
    parameter int                 EXEC_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data,
    output logic [15:0]       fullBitNum,
    input  logic              pc_inc,
    input  logic              exec_done,
    output logic              busy,
    output logic              illegal,
    output logic              halted,
    output logic              fault
);

    localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_RETIRE = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [15:0]        r_ir;
    logic [15:0]        r_full;
    logic               r_illegal;
    logic               r_fault;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_illegal;
    logic               w_timeout;
    logic               w_pc_step;
    logic [3:0]         w_opcode;

    assign w_opcode   = r_ir[15:12];
    assign mem_addr   = r_pc;
    assign mem_rd     = (r_state == S_FETCH);
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted     = (r_state == S_HALT);
    assign fullBitNum = r_full;
    assign illegal    = r_illegal;
    assign fault      = r_fault;

    // Next-state decode plus the single-cycle control strobes derived from it.
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        w_timeout = 1'b0;
        w_pc_step = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_LATCH;
            S_LATCH: begin
                w_pc_step = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                if (w_opcode == OP_HALT) begin
                    w_next = S_HALT;
                end else if (OP_VALID[w_opcode]) begin
                    w_next = S_EXEC;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = S_RETIRE;
                end
            end
            S_EXEC: begin
                w_pc_step = pc_inc;
                // done takes priority over a timeout landing on the same cycle
                if (exec_done) begin
                    w_next = S_RETIRE;
                end else if (r_cnt == CNT_W'(EXEC_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_RETIRE: w_next = run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // PC and IR: PC wraps naturally at 2^ADDR_W; IR loads only on the accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else begin
            if (w_pc_step)                      r_pc <= r_pc + ADDR_W'(1);
            if (r_state == S_FETCH && mem_ready) r_ir <= mem_data;
        end
    end

    // Registered outputs: instruction is exposed only while in EXEC, strobes and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_full    <= (w_next == S_EXEC) ? r_ir : 16'h0000;
            r_illegal <= w_illegal;
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    // EXEC cycle counter: zero outside EXEC so it starts clean on every entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_EXEC) r_cnt <= '0;
        else                          r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: default instance plus a 4-bit-PC instance for wrap.
// Inputs driven 1 time unit after the rising edge; outputs checked at the same point.
// Every wait is a fixed-length loop; a watchdog ends the run if time runs away.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] fullBitNum;
    logic        pc_inc;
    logic        exec_done;
    logic        busy, illegal, halted, fault;

    logic        b_run;
    logic [3:0]  b_mem_addr;
    logic        b_mem_rd;
    logic [15:0] b_fullBitNum;
    logic        b_pc_inc, b_exec_done;
    logic        b_busy, b_illegal, b_halted, b_fault;

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Garbage on the bus while not ready, so a premature IR load would be visible.
    assign mem_data = mem_ready ? mem[mem_addr] : 16'hD00D;

    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_data(mem_data),
        .fullBitNum(fullBitNum), .pc_inc(pc_inc), .exec_done(exec_done),
        .busy(busy), .illegal(illegal), .halted(halted), .fault(fault)
    );

    instr_fetch_ctrl #(.ADDR_W(4), .RESET_PC(4'd14)) dut_b (
        .clk(clk), .rst(rst), .run(b_run),
        .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_ready(1'b1), .mem_data(16'h1000),
        .fullBitNum(b_fullBitNum), .pc_inc(b_pc_inc), .exec_done(b_exec_done),
        .busy(b_busy), .illegal(b_illegal), .halted(b_halted), .fault(b_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1083;
        mem[1] = 16'h2000;
        mem[3] = 16'h7000;
        mem[4] = 16'hF000;
        rst = 1'b1; run = 1'b0; mem_ready = 1'b1; pc_inc = 1'b0; exec_done = 1'b0;
        b_run = 1'b0; b_pc_inc = 1'b0; b_exec_done = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_full", fullBitNum, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_addr", mem_addr, 0);

        // instruction 16'h1083, done on the 9th EXEC cycle
        run = 1'b1;
        step();                                   // FETCH
        check("f0_rd", mem_rd, 1);
        check("f0_addr", mem_addr, 0);
        check("f0_busy", busy, 1);
        step();                                   // LATCH
        check("l0_rd", mem_rd, 0);
        check("l0_full", fullBitNum, 0);
        step();                                   // DECODE
        check("d0_addr", mem_addr, 1);
        check("d0_full", fullBitNum, 0);
        for (int k = 1; k <= 9; k++) begin
            step();                               // EXEC cycle k
            check("e0_full", fullBitNum, 16'h1083);
            if (k == 9) exec_done = 1'b1;
        end
        step();                                   // RETIRE
        exec_done = 1'b0;
        check("r0_full", fullBitNum, 0);
        check("r0_rd", mem_rd, 0);
        step();                                   // FETCH addr 1
        check("f1_addr", mem_addr, 1);
        check("f1_rd", mem_rd, 1);

        // withhold mem_ready for 5 cycles
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("wait_rd", mem_rd, 1);
            check("wait_addr", mem_addr, 1);
            step();
        end
        mem_ready = 1'b1;
        check("wait_rd_last", mem_rd, 1);
        step();                                   // LATCH
        check("l1_rd", mem_rd, 0);
        step();                                   // DECODE
        check("d1_addr", mem_addr, 2);
        step();                                   // EXEC
        check("e1_full", fullBitNum, 16'h2000);
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        check("e1_pcinc", mem_addr, 3);
        exec_done = 1'b1;
        step();                                   // RETIRE
        exec_done = 1'b0;
        run = 1'b0;
        check("r1_full", fullBitNum, 0);
        step();                                   // IDLE
        check("idle_busy", busy, 0);
        check("idle_rd", mem_rd, 0);
        check("idle_addr", mem_addr, 3);

        // illegal opcode then halt
        run = 1'b1;
        step(); step(); step();                   // FETCH, LATCH, DECODE of 7000
        step();                                   // RETIRE
        check("ill_pulse", illegal, 1);
        check("ill_full", fullBitNum, 0);
        step();                                   // FETCH addr 4
        check("ill_clear", illegal, 0);
        check("ill_next", mem_addr, 4);
        step(); step();                           // LATCH, DECODE of F000
        step();                                   // HALT
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_illegal", illegal, 0);
        for (int k = 0; k < 3; k++) begin
            check("halt_rd", mem_rd, 0);
            step();
        end
        reset_pulse();
        check("hrst_halted", halted, 0);
        check("hrst_addr", mem_addr, 0);

        // execute timeout: 32 EXEC cycles without done
        run = 1'b1;
        step(); step(); step(); step();           // FETCH..EXEC1
        check("to_full1", fullBitNum, 16'h1083);
        for (int k = 2; k <= 32; k++) step();
        check("to_e32_fault", fault, 0);
        check("to_e32_full", fullBitNum, 16'h1083);
        step();
        check("to_fault", fault, 1);
        check("to_halted", halted, 1);
        check("to_full", fullBitNum, 0);
        check("to_busy", busy, 0);
        run = 1'b0;
        reset_pulse();
        check("torst_fault", fault, 0);
        check("torst_halted", halted, 0);
        check("torst_addr", mem_addr, 0);
        check("torst_full", fullBitNum, 0);
        check("torst_busy", busy, 0);

        // done on the timeout cycle wins
        run = 1'b1;
        step(); step(); step(); step();
        for (int k = 2; k <= 32; k++) step();
        exec_done = 1'b1;
        step();                                   // RETIRE
        exec_done = 1'b0;
        run = 1'b0;
        check("tie_fault", fault, 0);
        check("tie_halted", halted, 0);
        check("tie_busy", busy, 1);
        step();
        check("tie_idle", busy, 0);

        // reset during FETCH
        run = 1'b1;
        step();
        check("fr_rd", mem_rd, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        check("fr_rd_after", mem_rd, 0);
        check("fr_busy", busy, 0);

        // 4-bit PC wrap via pc_inc
        b_run = 1'b1;
        step();
        check("b_f_addr", b_mem_addr, 14);
        step(); step();                           // LATCH, DECODE
        check("b_d_addr", b_mem_addr, 15);
        step();                                   // EXEC
        check("b_e_full", b_fullBitNum, 16'h1000);
        b_pc_inc = 1'b1;
        step();
        b_pc_inc = 1'b0;
        check("b_wrap", b_mem_addr, 0);
        b_exec_done = 1'b1;
        step();
        b_exec_done = 1'b0;
        b_run = 1'b0;
        step();
        check("b_idle_addr", b_mem_addr, 0);
        check("b_idle_busy", b_busy, 0);
        check("b_flags", {b_illegal, b_halted, b_fault, b_mem_rd}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
